ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte (reset 0xFF, set-LEDs 0xED, enable 0xF4) to the attached keyboard over the shared ps2_clk/ps2_data open-drain lines.
- Drives the opposite direction of the existing keyboard receive path. Sits beside it under the pong top level, on the 100 MHz system clock.
- The top level builds the inout buffers: line = oe ? 1'b0 : 1'bz.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 50 +++++
 rtl/ps2_host_tx.sv | 175 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command bytes and
// the odd-parity helper used when framing a byte.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  // Frame bits after the start bit: d0..d7, parity, stop.
  localparam int PS2_FRAME_BITS = 10;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the open-drain ps2_clk/ps2_data lines into the system clock domain
// and flags each falling edge of the synchronized PS/2 clock. Shared with the
// keyboard receive path.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fe
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  // Shift each line one stage down its synchronizer chain and remember the last synchronized clock.
  always_comb begin
    clk_sync_d[0]  = ps2_clk_in;
    data_sync_d[0] = ps2_data_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      clk_sync_d[i]  = clk_sync_q[i-1];
      data_sync_d[i] = data_sync_q[i-1];
    end
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
  end

  // Idle lines float high, so everything resets to 1 and no edge is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign clk_fe = clk_prev_q & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device-generated clock edges and checks the
// device ACK. Line drivers are open-drain enables (1 = pull low).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e                  state_q, state_d;
  logic [INH_W-1:0]            inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
  logic [3:0]                  bit_cnt_q, bit_cnt_d;
  logic [3:0]                  bit_nxt;
  logic [PS2_FRAME_BITS-1:0]   frame_q, frame_d;
  logic                        clk_oe_q, clk_oe_d;
  logic                        data_oe_q, data_oe_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        clk_s, data_s, clk_fe;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .clk_fe     (clk_fe)
  );

  assign bit_nxt = bit_cnt_q + 4'd1;

  // Next-state logic; line enables are computed one cycle ahead so the registered outputs match the state.
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_d   = {1'b1, odd_parity(tx_data), tx_data};
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        if (inh_cnt_q == INH_DATA) begin
          data_oe_d = 1'b1;
        end
        if (inh_cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = REQ;
        end
      end

      REQ, SEND, ACK, WAIT_IDLE: begin
        if (to_cnt_q == TO_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (state_q == REQ) begin
            if (clk_fe) begin
              data_oe_d = ~frame_q[0];
              bit_cnt_d = 4'd0;
              state_d   = SEND;
            end
          end else if (state_q == SEND) begin
            if (clk_fe) begin
              data_oe_d = ~frame_q[bit_nxt];
              bit_cnt_d = bit_nxt;
              if (bit_cnt_q == 4'd8) begin
                state_d = ACK;
              end
            end
          end else if (state_q == ACK) begin
            if (clk_fe) begin
              if (!data_s) begin
                state_d = WAIT_IDLE;
              end else begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end
          end else begin
            if (clk_s && data_s) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State, counters and all outputs are registered so the open-drain enables never glitch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // A finishing pulse blocks acceptance for its one cycle so requests never overlap the report.
  assign tx_ready    = (state_q == IDLE) && !done_q && !err_q;
  assign busy        = (state_q != IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 keyboard model clocks frames out of the
// host, and a scoreboard holds the bytes the host should put on the wire.
// Timing parameters are scaled down so every scenario fits a short run.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH   = 120;
  localparam int TO    = 3000;
  localparam int H     = 40;
  localparam int BOUND = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb[$];

  int   done_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  logic last_busy = 1'b0, last_ready = 1'b0, last_oe = 1'b0;
  logic next_ready = 1'b0, next_oe = 1'b0;
  logic pulse_prev = 1'b0;

  // Pulse monitor: counts done/err cycles and snapshots the outputs at and after each pulse.
  always @(negedge clk) begin
    if (pulse_prev) begin
      next_ready = tx_ready;
      next_oe    = ps2_clk_oe | ps2_data_oe;
    end
    pulse_prev = tx_done | tx_err;
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
    if (tx_done | tx_err) begin
      last_busy  = busy;
      last_ready = tx_ready;
      last_oe    = ps2_clk_oe | ps2_data_oe;
    end
  end

  // Global watchdog so a stuck DUT still ends the run.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    sb.push_back(d);
    step();
    tx_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL accept_%02h: busy got %b expected 1", d, busy);
    end
  endtask

  // Keyboard model: waits for the request, clocks 11 pulses, samples bits on rising edges, optionally ACKs.
  task automatic device_frame(input bit do_ack, input bit check_inh, input int abort_at);
    int          inh;
    int          guard;
    int          ones;
    bit          found;
    logic        last_dat;
    logic [10:0] bits;
    logic [10:0] exp_bits;
    logic [7:0]  exp_byte;
    inh = 0; guard = 0; found = 0; last_dat = 1'b0; bits = '0;
    while (guard < BOUND) begin
      if (ps2_clk_oe) begin
        inh++;
        last_dat = ps2_data_oe;
      end else if (ps2_data_oe) begin
        found = 1;
        break;
      end
      step();
      guard++;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("[TB] FAIL req_wait: got no request expected request within %0d cycles", BOUND);
      if (sb.size() > 0) exp_byte = sb.pop_front();
      return;
    end
    if (check_inh) begin
      n_cmp++;
      if (inh != INH) begin
        n_bad++;
        $display("[TB] FAIL inhibit_len: got %0d expected %0d", inh, INH);
      end
      n_cmp++;
      if (last_dat !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL inhibit_last_data_oe: got %b expected 1", last_dat);
      end
    end
    repeat (10) step();
    bits[0] = ps2_data_line;
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      if (i == abort_at) begin
        repeat (4) step();
        if (sb.size() > 0) exp_byte = sb.pop_front();
        return;
      end
      repeat (H) step();
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = ps2_data_line;
      if (i == 10 && do_ack) begin
        repeat (H / 2) step();
        dev_data = 1'b0;
        repeat (H / 2) step();
      end else begin
        repeat (H) step();
      end
    end
    dev_data = 1'b1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard: got frame %03h expected no frame", bits);
    end else begin
      exp_byte = sb.pop_front();
      ones = 0;
      exp_bits[0] = 1'b0;
      for (int j = 0; j < 8; j++) begin
        exp_bits[j+1] = exp_byte[j];
        if (exp_byte[j]) ones++;
      end
      exp_bits[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
      exp_bits[10] = 1'b1;
      if (bits !== exp_bits) begin
        n_bad++;
        $display("[TB] FAIL frame_%02h: got bits %03h expected %03h", exp_byte, bits, exp_bits);
      end
    end
  endtask

  task automatic wait_pulse(input int start_total, output bit seen);
    seen = 0;
    for (int k = 0; k < BOUND; k++) begin
      if (done_cnt + err_cnt != start_total) begin
        seen = 1;
        break;
      end
      step();
    end
    repeat (3) step();
  endtask

  task automatic check_outcome(input string name, input int d_exp, input int e_exp, input bit seen);
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("[TB] FAIL %s_pulse: got none expected done/err within %0d cycles", name, BOUND);
    end
    n_cmp++;
    if (done_cnt != d_exp || err_cnt != e_exp) begin
      n_bad++;
      $display("[TB] FAIL %s_counts: got done=%0d err=%0d expected done=%0d err=%0d",
               name, done_cnt, err_cnt, d_exp, e_exp);
    end
    n_cmp++;
    if (last_busy !== 1'b0 || last_ready !== 1'b0 || last_oe !== 1'b0 || next_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL %s_release: got busy=%b ready=%b oe=%b ready_next=%b expected 0 0 0 1",
               name, last_busy, last_ready, last_oe, next_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err} !== 5'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000",
               {ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err});
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_ready: got %b expected 1", tx_ready);
    end
  endtask

  task automatic test_send_f4();
    int d0, e0;
    bit seen;
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(PS2_CMD_ENABLE);
    device_frame(1'b1, 1'b1, 0);
    wait_pulse(d0 + e0, seen);
    check_outcome("send_f4", d0 + 1, e0, seen);
  endtask

  task automatic test_parity();
    logic [7:0] cmds[3];
    int d0, e0;
    bit seen;
    cmds[0] = PS2_CMD_SET_LEDS; cmds[1] = 8'h00; cmds[2] = PS2_CMD_RESET;
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt; e0 = err_cnt;
      send_cmd(cmds[i]);
      device_frame(1'b1, 1'b1, 0);
      wait_pulse(d0 + e0, seen);
      check_outcome($sformatf("parity_%02h", cmds[i]), d0 + 1, e0, seen);
    end
  endtask

  task automatic test_no_ack();
    int d0, e0;
    bit seen;
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(8'h5A);
    device_frame(1'b0, 1'b1, 0);
    wait_pulse(d0 + e0, seen);
    check_outcome("no_ack", d0, e0 + 1, seen);
  endtask

  task automatic test_timeout();
    int d0, e0, cnt, guard;
    d0 = done_cnt; e0 = err_cnt;
    tx_data  = PS2_CMD_ENABLE;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    guard = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && guard < BOUND) begin
      step();
      guard++;
    end
    cnt = 0;
    while (cnt < TO + 100) begin
      step();
      cnt++;
      if (tx_err) break;
    end
    n_cmp++;
    if (cnt != TO) begin
      n_bad++;
      $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", cnt, TO);
    end
    n_cmp++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL timeout_lines: got clk_oe=%b data_oe=%b expected 0 0", ps2_clk_oe, ps2_data_oe);
    end
    repeat (3) step();
    n_cmp++;
    if (done_cnt != d0 || err_cnt != e0 + 1) begin
      n_bad++;
      $display("[TB] FAIL timeout_counts: got done=%0d err=%0d expected done=%0d err=%0d",
               done_cnt, err_cnt, d0, e0 + 1);
    end
  endtask

  task automatic test_reset_midframe();
    int d0, e0;
    bit seen;
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(8'h3C);
    device_frame(1'b1, 1'b1, 5);
    reset = 1'b0;
    step();
    n_cmp++;
    if ({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err} !== 5'b0) begin
      n_bad++;
      $display("[TB] FAIL midframe_reset: got %b expected 00000",
               {ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err});
    end
    repeat (3) step();
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    reset    = 1'b1;
    repeat (5) step();
    n_cmp++;
    if (done_cnt != d0 || err_cnt != e0) begin
      n_bad++;
      $display("[TB] FAIL midframe_pulses: got done=%0d err=%0d expected done=%0d err=%0d",
               done_cnt, err_cnt, d0, e0);
    end
    send_cmd(PS2_CMD_RESET);
    device_frame(1'b1, 1'b1, 0);
    wait_pulse(d0 + e0, seen);
    check_outcome("after_reset", d0 + 1, e0, seen);
  endtask

  task automatic test_back_to_back();
    int d0, e0, guard;
    bit seen;
    d0 = done_cnt; e0 = err_cnt;
    tx_data  = PS2_CMD_ENABLE;
    tx_valid = 1'b1;
    sb.push_back(PS2_CMD_ENABLE);
    step();
    fork
      device_frame(1'b1, 1'b1, 0);
      begin
        for (int k = 0; k < BOUND; k++) begin
          tx_data = 8'($urandom_range(0, 255));
          if (done_cnt != d0 || err_cnt != e0) break;
          step();
        end
        tx_data = PS2_CMD_SET_LEDS;
        sb.push_back(PS2_CMD_SET_LEDS);
      end
    join
    n_cmp++;
    if (done_cnt != d0 + 1 || last_ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL b2b_first: got done=%0d ready_at_pulse=%b expected done=%0d ready 0",
               done_cnt, last_ready, d0 + 1);
    end
    guard = 0;
    while (!busy && guard < 10) begin
      step();
      guard++;
    end
    tx_valid = 1'b0;
    n_cmp++;
    if (guard != 2) begin
      n_bad++;
      $display("[TB] FAIL b2b_accept_delay: got %0d cycles expected 2", guard);
    end
    device_frame(1'b1, 1'b0, 0);
    wait_pulse(d0 + 1 + e0, seen);
    check_outcome("b2b_second", d0 + 2, e0, seen);
  endtask

  initial begin
    test_reset();
    test_send_f4();
    test_parity();
    test_no_ack();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    n_cmp++;
    if (both_cnt != 0 || sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL exclusive_and_drained: got both=%0d left=%0d expected 0 0", both_cnt, sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
